// File: rtl/ysyx_csr_trap_seq_if.sv
// Commit-stage / CSR-file bundle seen by the trap sequencer.
// The master side is the commit stage plus CSR file; the sequencer is the slave.
interface ysyx_csr_trap_seq_if #(
  parameter int XLEN = 32,
  parameter int R_W  = 12
);
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic            mret_valid;
  logic            irq_timer;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] csr_mstatus;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            inst_csr_wen;
  logic [R_W-1:0]  inst_csr_waddr;
  logic [XLEN-1:0] inst_csr_wdata;
  logic            inst_csr_ready;
  logic            csr_wen;
  logic [R_W-1:0]  csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            trap_ack;
  logic            busy;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output exc_valid, exc_cause, mret_valid, irq_timer, commit_pc,
           csr_mstatus, csr_mtvec, csr_mepc,
           inst_csr_wen, inst_csr_waddr, inst_csr_wdata,
    input  inst_csr_ready, csr_wen, csr_waddr, csr_wdata,
           trap_ack, busy, redirect_valid, redirect_pc
  );

  modport slave (
    input  exc_valid, exc_cause, mret_valid, irq_timer, commit_pc,
           csr_mstatus, csr_mtvec, csr_mepc,
           inst_csr_wen, inst_csr_waddr, inst_csr_wdata,
    output inst_csr_ready, csr_wen, csr_waddr, csr_wdata,
           trap_ack, busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_csr_trap_seq.sv
// Serialises trap entry / mret CSR updates onto the single CSR write port and
// issues the fetch redirect; instruction CSR writes pass through when idle.
module ysyx_csr_trap_seq #(
  parameter int XLEN = 32,
  parameter int R_W  = 12
) (
  input logic              clock,
  input logic              reset,
  ysyx_csr_trap_seq_if.slave bus
);
  localparam logic [R_W-1:0] A_MSTATUS = R_W'(12'h300);
  localparam logic [R_W-1:0] A_MEPC    = R_W'(12'h341);
  localparam logic [R_W-1:0] A_MCAUSE  = R_W'(12'h342);
  localparam logic [XLEN-1:0] IRQ_TIMER_CAUSE = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STAT, M_STAT, REDIR} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q, cause_q, target_q;
  logic            is_irq_q, is_mret_q;

  logic            take_exc, take_irq, take_mret;
  logic            csr_wen, inst_csr_ready, trap_ack, redirect_valid;
  logic [R_W-1:0]  csr_waddr;
  logic [XLEN-1:0] csr_wdata, redirect_pc;
  logic [XLEN-1:0] mst_trap, mst_ret, base, vec_off;

  assign take_exc  = (state == IDLE) && bus.exc_valid;
  assign take_irq  = (state == IDLE) && !bus.exc_valid && bus.irq_timer && bus.csr_mstatus[3];
  assign take_mret = (state == IDLE) && !bus.exc_valid && !(bus.irq_timer && bus.csr_mstatus[3])
                     && bus.mret_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      target_q  <= '0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_exc || take_irq) begin
        pc_q      <= bus.commit_pc;
        cause_q   <= take_exc ? XLEN'(bus.exc_cause) : IRQ_TIMER_CAUSE;
        is_irq_q  <= take_irq;
        is_mret_q <= 1'b0;
      end else if (take_mret) begin
        target_q  <= bus.csr_mepc;
        is_irq_q  <= 1'b0;
        is_mret_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    inst_csr_ready = 1'b0;
    trap_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    mst_trap        = bus.csr_mstatus;
    mst_trap[7]     = bus.csr_mstatus[3];
    mst_trap[3]     = 1'b0;
    mst_trap[12:11] = 2'b11;
    mst_ret         = bus.csr_mstatus;
    mst_ret[3]      = bus.csr_mstatus[7];
    mst_ret[7]      = 1'b1;

    base    = {bus.csr_mtvec[XLEN-1:2], 2'b00};
    vec_off = {cause_q[XLEN-3:0], 2'b00};

    case (state)
      IDLE: begin
        if (take_exc || take_irq) begin
          trap_ack  = 1'b1;
          state_nxt = W_EPC;
        end else if (take_mret) begin
          trap_ack  = 1'b1;
          state_nxt = M_STAT;
        end else if (bus.inst_csr_wen) begin
          csr_wen        = 1'b1;
          csr_waddr      = bus.inst_csr_waddr;
          csr_wdata      = bus.inst_csr_wdata;
          inst_csr_ready = 1'b1;
        end
      end
      W_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = pc_q;
        state_nxt = W_CAUSE;
      end
      W_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MCAUSE;
        csr_wdata = cause_q;
        state_nxt = W_STAT;
      end
      W_STAT: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = mst_trap;
        state_nxt = REDIR;
      end
      M_STAT: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = mst_ret;
        state_nxt = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        // reserved mtvec modes fall back to the direct base
        if (is_mret_q)                                redirect_pc = target_q;
        else if (bus.csr_mtvec[1:0] == 2'b01 && is_irq_q) redirect_pc = base + vec_off;
        else                                          redirect_pc = base;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // reset silences the port in the same cycle so an aborted sequence leaves no trace
    if (reset) begin
      state_nxt      = IDLE;
      csr_wen        = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      inst_csr_ready = 1'b0;
      trap_ack       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  assign bus.csr_wen        = csr_wen;
  assign bus.csr_waddr      = csr_waddr;
  assign bus.csr_wdata      = csr_wdata;
  assign bus.inst_csr_ready = inst_csr_ready;
  assign bus.trap_ack       = trap_ack;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.busy           = (state != IDLE) && !reset;
endmodule

// File: doc/ysyx_csr_trap_seq.md
Name: ysyx_csr_trap_seq

Overview:
- Sequences all trap-related updates to the machine CSR file, which has a single write port: ecall/exception entry, timer-interrupt entry and mret.
- Arbitrates that port between trap sequences and instruction-driven CSR writes (csrrw/csrrs/csrrc).
- Produces the PC redirect and pipeline flush at trap entry and at mret return.
- Sits between the commit stage and the CSR file.

Parameters:
- XLEN, 32, datapath width.
- R_W, 12, CSR address width.

Ports:
- clock  in  1  clock
- reset  in  1  reset
- exc_valid  in  1  commit-stage exception request; single-cycle pulse
- exc_cause  in  4  exception code; 11 = ecall-M
- mret_valid  in  1  commit-stage mret; single-cycle pulse
- irq_timer  in  1  level machine-timer interrupt pending
- commit_pc  in  XLEN  PC of the faulting instruction, or of the next instruction for an interrupt
- csr_mstatus  in  XLEN  current mstatus from CSR file
- csr_mtvec  in  XLEN  current mtvec
- csr_mepc  in  XLEN  current mepc
- inst_csr_wen  in  1  instruction CSR write request
- inst_csr_waddr  in  R_W  instruction CSR address
- inst_csr_wdata  in  XLEN  instruction CSR data
- inst_csr_ready  out  1  instruction write accepted this cycle
- csr_wen  out  1  CSR file write enable
- csr_waddr  out  R_W  CSR file write address
- csr_wdata  out  XLEN  CSR file write data
- trap_ack  out  1  pulse: trap or mret accepted this cycle
- busy  out  1  sequence in progress; commit stalls
- redirect_valid  out  1  one-cycle pulse: fetch redirect plus flush
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (reset: synchronous, active-high; clock: clock):
  - State goes to IDLE.
  - All outputs are 0; latched pc, cause and target registers are cleared.
  - Reset asserted mid-sequence aborts it. No further CSR write and no redirect is issued.
- States: IDLE, W_EPC, W_CAUSE, W_STAT, M_STAT, REDIR. busy = (state != IDLE).
- IDLE priority, highest first:
  1. exc_valid: latch pc = commit_pc; cause = zero-extended exc_cause; is_irq = 0; go to W_EPC.
  2. irq_timer & csr_mstatus[3] (MIE): latch pc = commit_pc; cause = 0x80000007; is_irq = 1; go to W_EPC.
  3. mret_valid: latch target = csr_mepc; go to M_STAT.
  4. inst_csr_wen: combinational pass-through. csr_wen/waddr/wdata = inst_* and inst_csr_ready = 1 in the same cycle.
- trap_ack pulses in the cycle a priority 1–3 request is accepted. In that cycle inst_csr_ready = 0 and csr_wen = 0.
- exc_valid and mret_valid arriving while busy are ignored. Upstream guarantees they are flushed.
- inst_csr_ready = 0 whenever busy.
- W_EPC: write mepc (0x341) = latched pc; go to W_CAUSE.
- W_CAUSE: write mcause (0x342) = latched cause; go to W_STAT.
- W_STAT: write mstatus (0x300) = csr_mstatus with:
  - MPIE[7] = MIE[3]
  - MIE[3] = 0
  - MPP[12:11] = 2'b11
  - all other bits unchanged.
  Go to REDIR.
- M_STAT: write mstatus = csr_mstatus with MIE[3] = MPIE[7] and MPIE[7] = 1; go to REDIR.
- REDIR: redirect_valid = 1 for one cycle, then go to IDLE.
- redirect_pc:
  - Trap, mtvec[1:0] == 0 (direct): {csr_mtvec[XLEN-1:2], 2'b00}.
  - Trap, mtvec[1:0] == 1 and is_irq: base + (cause[XLEN-2:0] << 2), truncated to XLEN.
  - mret: the target latched at acceptance.
  - csr_mtvec is sampled in REDIR; no other writer can modify it while busy.
- Latency:
  - Trap accepted at cycle T: CSR writes at T+1..T+3, redirect at T+4.
  - mret accepted at T: write at T+1, redirect at T+2.
- Exactly one CSR write per cycle; csr_wen = 0 in REDIR and in idle cycles with no request.
- An exception arriving together with irq and mret: the exception wins. irq remains pending and is taken after return once MIE = 1.

Test Plan:
- Reset then idle: all outputs 0, busy = 0 for 10 cycles.
- ecall: exc_valid, exc_cause = 11, commit_pc = 0x80000010, mstatus = 0x8, mtvec = 0x80001000 → trap_ack at T.
  - T+1: write 0x341 = 0x80000010.
  - T+2: write 0x342 = 0xB.
  - T+3: write 0x300 = 0x1880.
  - T+4: redirect to 0x80001000.
- mret: mstatus = 0x1880, mepc = 0x80000014 → T+1: write 0x300 = 0x1888; T+2: redirect to 0x80000014.
- Vectored timer interrupt: irq_timer = 1, MIE = 1, mtvec = 0x80001001, commit_pc = 0x80000020 → mcause write 0x80000007; redirect to 0x8000101C.
- Arbitration:
  - inst_csr_wen held with exc_valid at T: no inst write at T; inst_csr_ready = 0 through T+4; inst write accepted at T+5.
  - irq with MIE = 0: ignored; inst write passes through.
- Reset asserted at T+2 of a trap: no mstatus write, no redirect, busy = 0 at T+3.
